// File: rtl/quad_pkg.sv
// Shared quadrature sequence definition for the generator and decoder sides.
// Contents: phase_t / state_t enums, phase stepping and phase<->{a,b} mapping.
// Phase encodings are ordered along the CW walk so stepping is a 2-bit add.
package quad_pkg;

  // Encoded in CW order so +1 is clockwise and -1 is counter-clockwise.
  typedef enum logic [1:0] {
    PH_00 = 2'd0,
    PH_10 = 2'd1,
    PH_11 = 2'd2,
    PH_01 = 2'd3
  } phase_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  function automatic phase_t phase_next_cw(input phase_t p);
    return phase_t'(p + 2'd1);
  endfunction

  function automatic phase_t phase_next_ccw(input phase_t p);
    return phase_t'(p - 2'd1);
  endfunction

  // Returns {a,b}.
  function automatic logic [1:0] phase_to_ab(input phase_t p);
    logic [1:0] ab;
    case (p)
      PH_00:   ab = 2'b00;
      PH_10:   ab = 2'b10;
      PH_11:   ab = 2'b11;
      PH_01:   ab = 2'b01;
      default: ab = 2'b00;
    endcase
    return ab;
  endfunction

  function automatic phase_t ab_to_phase(input logic [1:0] ab);
    phase_t p;
    case (ab)
      2'b00:   p = PH_00;
      2'b10:   p = PH_10;
      2'b11:   p = PH_11;
      2'b01:   p = PH_01;
      default: p = PH_00;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/quadrature_generator.sv
// Quadrature generator: turns handshaked step requests into registered A/B
// levels with a minimum hold between edges and a signed position count.
// Ports: clk/rst, step_valid/step_dir/step_ready, zero, a/b, busy, position.
module quadrature_generator
  import quad_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int POS_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_valid,
  input  logic                    step_dir,
  output logic                    step_ready,
  input  logic                    zero,
  output logic                    a,
  output logic                    b,
  output logic                    busy,
  output logic signed [POS_W-1:0] position
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  phase_t           phase;
  phase_t           phase_nxt;
  logic [1:0]       ab_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic [POS_W-1:0] pos_base;
  logic [POS_W-1:0] pos_delta;

  // In S_IDLE the counter is always zero, so the hold test alone suffices
  // for the HOLD case; IDLE is listed explicitly for clarity.
  assign step_ready = (state == S_IDLE) || (cnt == '0);
  assign accept     = step_valid && step_ready;

  always_comb begin
    phase_nxt = step_dir ? phase_next_cw(phase) : phase_next_ccw(phase);
    ab_nxt    = phase_to_ab(phase_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      phase <= PH_00;
      cnt   <= '0;
      busy  <= 1'b0;
      a     <= 1'b0;
      b     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_HOLD;
            busy  <= 1'b1;
            cnt   <= HOLD_LOAD;
          end
        end
        S_HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (accept) begin
            cnt <= HOLD_LOAD;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase

      // A/B come straight from flops; only one bit differs between
      // neighbouring phases, so every update is a single-channel edge.
      if (accept) begin
        phase <= phase_nxt;
        a     <= ab_nxt[1];
        b     <= ab_nxt[0];
      end
    end
  end

  // Clear takes effect before a coincident step, so the result is +/-1.
  always_comb begin
    pos_base  = zero ? '0 : position;
    pos_delta = step_dir ? POS_W'(1) : {POS_W{1'b1}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      position <= '0;
    end else if (accept) begin
      position <= pos_base + pos_delta;
    end else if (zero) begin
      position <= '0;
    end
  end

endmodule
